// File: rtl/fft_note_detector.sv
// Frame-level note detector: |X|^2 per FFT bin, windowed peak search, bin-to-note lookup
// and snapping to the nearest note allowed by a 12-bit scale mask.
//
// state  | meaning
// IDLE   | waiting for an accepted bin 0 to start a frame
// ACCUM  | streaming bins through the magnitude pipeline
// DRAIN  | two cycles to flush the pipeline, then threshold test
// LOOKUP | peak bin presented to the bin-to-note ROM
// SNAP   | search outward from the raw note, one distance per cycle
// DONE   | one-cycle note_done pulse
module fft_note_detector #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 9,
    parameter int MAG_W  = 2*DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fft_done,
    input  logic                     fft_read_valid,
    input  logic [ADDR_W-1:0]        fft_address,
    input  logic signed [DATA_W-1:0] data_in_real,
    input  logic signed [DATA_W-1:0] data_in_imag,
    input  logic [ADDR_W-1:0]        min_bin,
    input  logic [ADDR_W-1:0]        max_bin,
    input  logic [MAG_W-1:0]         threshold,
    input  logic [11:0]              scale,
    output logic [ADDR_W-1:0]        lut_addr,
    input  logic [6:0]               lut_data,
    input  logic [ADDR_W-1:0]        result_address,
    output logic [MAG_W-1:0]         result_data,
    output logic                     busy,
    output logic                     note_done,
    output logic                     note_valid,
    output logic [3:0]               note_name,
    output logic [2:0]               note_octave,
    output logic [ADDR_W-1:0]        peak_bin,
    output logic [MAG_W-1:0]         peak_mag
);
    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, LOOKUP, SNAP, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [3:0]          raw_name_q, raw_name_d;
    logic [2:0]          raw_oct_q, raw_oct_d;
    logic [ADDR_W-1:0]   lut_addr_q, lut_addr_d;
    logic [MAG_W-1:0]    run_mag_q, run_mag_d;
    logic [ADDR_W-1:0]   run_bin_q, run_bin_d;
    logic [ADDR_W-1:0]   peak_bin_q, peak_bin_d;
    logic [MAG_W-1:0]    peak_mag_q, peak_mag_d;
    logic [3:0]          note_name_q, note_name_d;
    logic [2:0]          note_octave_q, note_octave_d;
    logic                note_valid_q, note_valid_d;
    logic [MAG_W-1:0]    s1_re_q, s1_re_d, s1_im_q, s1_im_d;
    logic                v1_q, v1_d;
    logic [ADDR_W-1:0]   a1_q, a1_d;
    logic [MAG_W-1:0]    result_data_q;

    logic [MAG_W-1:0]    mem [0:(1<<ADDR_W)-1];

    logic signed [2*DATA_W-1:0] re_ext, im_ext;
    logic [2*DATA_W-1:0] re_sq, im_sq;
    logic [MAG_W-1:0]    sum;
    logic                accept, take, finish, fin_valid;
    logic [3:0]          fin_name, n, up_name, dn_name;
    logic [2:0]          fin_oct, o, up_oct, dn_oct;
    logic [4:0]          up_sum, up_wrap, dn_wrap;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        raw_name_d    = raw_name_q;
        raw_oct_d     = raw_oct_q;
        lut_addr_d    = lut_addr_q;
        run_mag_d     = run_mag_q;
        run_bin_d     = run_bin_q;
        peak_bin_d    = peak_bin_q;
        peak_mag_d    = peak_mag_q;
        note_name_d   = note_name_q;
        note_octave_d = note_octave_q;
        note_valid_d  = note_valid_q;
        take          = 1'b0;
        finish        = 1'b0;
        fin_valid     = 1'b0;
        fin_name      = 4'd0;
        fin_oct       = 3'd0;
        accept        = fft_done && fft_read_valid;

        re_ext  = {{DATA_W{data_in_real[DATA_W-1]}}, data_in_real};
        im_ext  = {{DATA_W{data_in_imag[DATA_W-1]}}, data_in_imag};
        re_sq   = re_ext * re_ext;
        im_sq   = im_ext * im_ext;
        s1_re_d = MAG_W'(re_sq);
        s1_im_d = MAG_W'(im_sq);
        a1_d    = fft_address;
        sum     = s1_re_q + s1_im_q;

        // strict compare keeps the lowest bin on ties
        if (v1_q && a1_q >= min_bin && a1_q <= max_bin && sum > run_mag_q) begin
            run_mag_d = sum;
            run_bin_d = a1_q;
        end

        // the raw note is only on lut_data during the first SNAP cycle
        n       = (cnt_q == 3'd0) ? lut_data[3:0] : raw_name_q;
        o       = (cnt_q == 3'd0) ? lut_data[6:4] : raw_oct_q;
        up_sum  = {1'b0, n} + {2'b0, cnt_q};
        up_wrap = up_sum - 5'd12;
        up_name = (up_sum >= 5'd12) ? up_wrap[3:0] : up_sum[3:0];
        up_oct  = (up_sum >= 5'd12 && o != 3'd7) ? o + 3'd1 : o;
        dn_wrap = {1'b0, n} + 5'd12 - {2'b0, cnt_q};
        dn_name = ({1'b0, cnt_q} > n) ? dn_wrap[3:0] : n - {1'b0, cnt_q};
        dn_oct  = ({1'b0, cnt_q} > n && o != 3'd0) ? o - 3'd1 : o;

        case (state_q)
            IDLE: begin
                if (accept && fft_address == '0) begin
                    state_d   = ACCUM;
                    take      = 1'b1;
                    run_mag_d = '0;
                    run_bin_d = '0;
                end
            end
            ACCUM: begin
                cnt_d = 3'd0;
                if (accept) begin
                    take = 1'b1;
                    if (fft_address == {ADDR_W{1'b1}}) state_d = DRAIN;
                end else if (!fft_done) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (cnt_q == 3'd1) begin
                    cnt_d = 3'd0;
                    if (run_mag_q > threshold) begin
                        state_d    = LOOKUP;
                        lut_addr_d = run_bin_q;
                    end else begin
                        finish = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            LOOKUP: state_d = SNAP;
            SNAP: begin
                raw_name_d = n;
                raw_oct_d  = o;
                if (n > 4'd11 || scale == 12'd0) begin
                    finish = 1'b1;
                end else if (scale[up_name]) begin
                    finish = 1'b1; fin_valid = 1'b1; fin_name = up_name; fin_oct = up_oct;
                end else if (scale[dn_name]) begin
                    finish = 1'b1; fin_valid = 1'b1; fin_name = dn_name; fin_oct = dn_oct;
                end else if (cnt_q == 3'd6) begin
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // results are loaded on entry to DONE so they are stable during note_done
        if (finish) begin
            state_d       = DONE;
            cnt_d         = 3'd0;
            peak_bin_d    = run_bin_q;
            peak_mag_d    = run_mag_q;
            note_valid_d  = fin_valid;
            note_name_d   = fin_name;
            note_octave_d = fin_oct;
        end
        v1_d = take;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            raw_name_q    <= '0;
            raw_oct_q     <= '0;
            lut_addr_q    <= '0;
            run_mag_q     <= '0;
            run_bin_q     <= '0;
            peak_bin_q    <= '0;
            peak_mag_q    <= '0;
            note_name_q   <= '0;
            note_octave_q <= '0;
            note_valid_q  <= 1'b0;
            s1_re_q       <= '0;
            s1_im_q       <= '0;
            v1_q          <= 1'b0;
            a1_q          <= '0;
            result_data_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            raw_name_q    <= raw_name_d;
            raw_oct_q     <= raw_oct_d;
            lut_addr_q    <= lut_addr_d;
            run_mag_q     <= run_mag_d;
            run_bin_q     <= run_bin_d;
            peak_bin_q    <= peak_bin_d;
            peak_mag_q    <= peak_mag_d;
            note_name_q   <= note_name_d;
            note_octave_q <= note_octave_d;
            note_valid_q  <= note_valid_d;
            s1_re_q       <= s1_re_d;
            s1_im_q       <= s1_im_d;
            v1_q          <= v1_d;
            a1_q          <= a1_d;
            result_data_q <= mem[result_address];
        end
    end

    // read-before-write: a same-address read returns the old word
    always_ff @(posedge clk) begin
        if (v1_q) mem[a1_q] <= sum;
    end

    assign lut_addr    = lut_addr_q;
    assign result_data = result_data_q;
    assign busy        = (state_q != IDLE);
    assign note_done   = (state_q == DONE);
    assign note_valid  = note_valid_q;
    assign note_name   = note_name_q;
    assign note_octave = note_octave_q;
    assign peak_bin    = peak_bin_q;
    assign peak_mag    = peak_mag_q;
endmodule

// File: tb/tb_fft_note_detector.sv
// Directed bench for fft_note_detector: full 512-bin frames with hand-computed peak,
// note, latency and magnitude-buffer expectations.
module tb_fft_note_detector;
    logic               clk = 1'b0;
    logic               reset;
    logic               fft_done, fft_read_valid;
    logic [8:0]         fft_address;
    logic signed [17:0] data_in_real, data_in_imag;
    logic [8:0]         min_bin, max_bin;
    logic [35:0]        threshold;
    logic [11:0]        scale;
    logic [8:0]         lut_addr;
    logic [6:0]         lut_data;
    logic [8:0]         result_address;
    logic [35:0]        result_data;
    logic               busy, note_done, note_valid;
    logic [3:0]         note_name;
    logic [2:0]         note_octave;
    logic [8:0]         peak_bin;
    logic [35:0]        peak_mag;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t_last = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic mid_busy;
    int re_arr [0:511];
    int im_arr [0:511];
    logic [6:0] lut_mem [0:511];

    fft_note_detector dut (
        .clk(clk), .reset(reset), .fft_done(fft_done), .fft_read_valid(fft_read_valid),
        .fft_address(fft_address), .data_in_real(data_in_real), .data_in_imag(data_in_imag),
        .min_bin(min_bin), .max_bin(max_bin), .threshold(threshold), .scale(scale),
        .lut_addr(lut_addr), .lut_data(lut_data), .result_address(result_address),
        .result_data(result_data), .busy(busy), .note_done(note_done), .note_valid(note_valid),
        .note_name(note_name), .note_octave(note_octave), .peak_bin(peak_bin), .peak_mag(peak_mag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) lut_data <= lut_mem[lut_addr];
    always @(negedge clk) if (note_done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end

    task automatic clear_frame();
        for (int i = 0; i < 512; i++) begin re_arr[i] = 0; im_arr[i] = 0; lut_mem[i] = 7'd0; end
    endtask

    // stop_at < 0 sends the whole frame; otherwise it is cut at that address
    task automatic drive_frame(input int stop_at, input bit do_reset);
        for (int a = 0; a < 512; a++) begin
            @(posedge clk); #1;
            if (a == 100) mid_busy = busy;
            if (a == stop_at) begin
                fft_done = 1'b0; fft_read_valid = 1'b0;
                if (do_reset) begin reset = 1'b1; @(posedge clk); #1; reset = 1'b0; end
                return;
            end
            fft_done = 1'b1; fft_read_valid = 1'b1; fft_address = 9'(a);
            data_in_real = 18'(re_arr[a]); data_in_imag = 18'(im_arr[a]);
            t_last = cyc;
        end
        @(posedge clk); #1;
        fft_done = 1'b0; fft_read_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %0d want 0", busy); end
        total++; if (note_done !== 1'b0) begin bad++; $display("FAIL reset note_done: got %0d want 0", note_done); end
        total++; if (note_valid !== 1'b0) begin bad++; $display("FAIL reset note_valid: got %0d want 0", note_valid); end
        total++; if ({note_name, note_octave} !== 7'd0) begin bad++; $display("FAIL reset note: got %0d/%0d want 0/0", note_name, note_octave); end
        total++; if (peak_bin !== 9'd0 || peak_mag !== 36'd0) begin bad++; $display("FAIL reset peak: got %0d/%0d want 0/0", peak_bin, peak_mag); end
        total++; if (lut_addr !== 9'd0 || result_data !== 36'd0) begin bad++; $display("FAIL reset lut/result: got %0d/%0d want 0/0", lut_addr, result_data); end
        reset = 1'b0;
    endtask

    task automatic test_single_peak(input string tag);
        int c0;
        clear_frame();
        re_arr[40] = 1000; lut_mem[40] = {3'd4, 4'd9};
        re_arr[100] = -3; im_arr[100] = 4;
        c0 = done_cnt;
        drive_frame(-1, 1'b0);
        repeat (12) @(negedge clk);
        total++; if (mid_busy !== 1'b1) begin bad++; $display("FAIL %s busy mid-frame: got %0d want 1", tag, mid_busy); end
        total++; if (done_cnt !== c0 + 1) begin bad++; $display("FAIL %s done count: got %0d want %0d", tag, done_cnt - c0, 1); end
        total++; if (done_cyc - t_last !== 5) begin bad++; $display("FAIL %s latency: got %0d want 5", tag, done_cyc - t_last); end
        total++; if (peak_bin !== 9'd40 || peak_mag !== 36'd1000000) begin bad++; $display("FAIL %s peak: got %0d/%0d want 40/1000000", tag, peak_bin, peak_mag); end
        total++; if (note_valid !== 1'b1 || note_name !== 4'd9 || note_octave !== 3'd4) begin bad++; $display("FAIL %s note: got v%0d %0d/%0d want v1 9/4", tag, note_valid, note_name, note_octave); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy after: got %0d want 0", tag, busy); end
        @(posedge clk); #1 result_address = 9'd40;
        @(posedge clk); #1;
        total++; if (result_data !== 36'd1000000) begin bad++; $display("FAIL %s ram[40]: got %0d want 1000000", tag, result_data); end
        result_address = 9'd100;
        @(posedge clk); #1;
        total++; if (result_data !== 36'd25) begin bad++; $display("FAIL %s ram[100]: got %0d want 25", tag, result_data); end
        result_address = 9'd41;
        @(posedge clk); #1;
        total++; if (result_data !== 36'd0) begin bad++; $display("FAIL %s ram[41]: got %0d want 0", tag, result_data); end
    endtask

    // one frame with bin 40 peaking, given raw LUT entry and scale
    task automatic test_snap(input string tag, input logic [6:0] lut_v, input logic [11:0] sc,
                             input int lat, input logic v, input logic [3:0] nm, input logic [2:0] oc);
        int c0;
        clear_frame();
        re_arr[40] = 1000; lut_mem[40] = lut_v; scale = sc;
        c0 = done_cnt;
        drive_frame(-1, 1'b0);
        repeat (14) @(negedge clk);
        total++; if (done_cnt !== c0 + 1) begin bad++; $display("FAIL %s done count: got %0d want 1", tag, done_cnt - c0); end
        total++; if (done_cyc - t_last !== lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", tag, done_cyc - t_last, lat); end
        total++; if (note_valid !== v) begin bad++; $display("FAIL %s valid: got %0d want %0d", tag, note_valid, v); end
        if (v) begin
            total++; if (note_name !== nm || note_octave !== oc) begin bad++; $display("FAIL %s note: got %0d/%0d want %0d/%0d", tag, note_name, note_octave, nm, oc); end
        end
        scale = 12'hFFF;
    endtask

    task automatic test_threshold_tie();
        int c0;
        clear_frame();
        re_arr[30] = 10; im_arr[30] = 20; re_arr[60] = 10; im_arr[60] = -20;
        lut_mem[30] = {3'd2, 4'd4}; lut_mem[60] = {3'd6, 4'd7};
        threshold = 36'd500;
        c0 = done_cnt;
        drive_frame(-1, 1'b0);
        repeat (12) @(negedge clk);
        total++; if (done_cnt !== c0 + 1) begin bad++; $display("FAIL thr500 done count: got %0d want 1", done_cnt - c0); end
        total++; if (done_cyc - t_last !== 3) begin bad++; $display("FAIL thr500 latency: got %0d want 3", done_cyc - t_last); end
        total++; if (note_valid !== 1'b0) begin bad++; $display("FAIL thr500 valid: got %0d want 0", note_valid); end
        total++; if (peak_mag !== 36'd500) begin bad++; $display("FAIL thr500 peak_mag: got %0d want 500", peak_mag); end
        threshold = 36'd499;
        c0 = done_cnt;
        drive_frame(-1, 1'b0);
        repeat (12) @(negedge clk);
        total++; if (done_cyc - t_last !== 5 || done_cnt !== c0 + 1) begin bad++; $display("FAIL thr499 latency: got %0d want 5", done_cyc - t_last); end
        total++; if (peak_bin !== 9'd30 || note_valid !== 1'b1) begin bad++; $display("FAIL thr499 tie: got bin %0d v%0d want bin 30 v1", peak_bin, note_valid); end
        total++; if (note_name !== 4'd4 || note_octave !== 3'd2) begin bad++; $display("FAIL thr499 note: got %0d/%0d want 4/2", note_name, note_octave); end
        threshold = 36'd0;
    endtask

    task automatic test_window();
        int c0;
        clear_frame();
        re_arr[5] = 100; re_arr[20] = 50;
        lut_mem[5] = {3'd1, 4'd1}; lut_mem[20] = {3'd5, 4'd2};
        min_bin = 9'd300; max_bin = 9'd100;
        c0 = done_cnt;
        drive_frame(-1, 1'b0);
        repeat (12) @(negedge clk);
        total++; if (done_cyc - t_last !== 3 || done_cnt !== c0 + 1) begin bad++; $display("FAIL empty window latency: got %0d want 3", done_cyc - t_last); end
        total++; if (note_valid !== 1'b0 || peak_mag !== 36'd0) begin bad++; $display("FAIL empty window: got v%0d mag %0d want v0 mag 0", note_valid, peak_mag); end
        min_bin = 9'd10; max_bin = 9'd511;
        drive_frame(-1, 1'b0);
        repeat (12) @(negedge clk);
        total++; if (peak_bin !== 9'd20 || peak_mag !== 36'd2500) begin bad++; $display("FAIL window peak: got %0d/%0d want 20/2500", peak_bin, peak_mag); end
        total++; if (note_valid !== 1'b1 || note_name !== 4'd2 || note_octave !== 3'd5) begin bad++; $display("FAIL window note: got v%0d %0d/%0d want v1 2/5", note_valid, note_name, note_octave); end
        min_bin = 9'd0;
    endtask

    task automatic test_abort();
        int c0;
        clear_frame();
        re_arr[40] = 1000; lut_mem[40] = {3'd4, 4'd9};
        c0 = done_cnt;
        drive_frame(200, 1'b0);
        repeat (12) @(negedge clk);
        total++; if (mid_busy !== 1'b1) begin bad++; $display("FAIL abort busy mid-frame: got %0d want 1", mid_busy); end
        total++; if (done_cnt !== c0) begin bad++; $display("FAIL abort note_done: got %0d pulses want 0", done_cnt - c0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort busy: got %0d want 0", busy); end
        total++; if (peak_bin !== 9'd20 || note_name !== 4'd2 || note_valid !== 1'b1) begin bad++; $display("FAIL abort hold: got bin %0d name %0d v%0d want 20 2 v1", peak_bin, note_name, note_valid); end
    endtask

    task automatic test_reset_mid();
        int c0;
        clear_frame();
        re_arr[40] = 1000; lut_mem[40] = {3'd4, 4'd9};
        c0 = done_cnt;
        drive_frame(150, 1'b1);
        total++; if (busy !== 1'b0 || note_valid !== 1'b0) begin bad++; $display("FAIL midreset busy/valid: got %0d/%0d want 0/0", busy, note_valid); end
        total++; if (peak_bin !== 9'd0 || peak_mag !== 36'd0 || {note_name, note_octave} !== 7'd0) begin bad++; $display("FAIL midreset outputs: got bin %0d mag %0d note %0d/%0d want 0", peak_bin, peak_mag, note_name, note_octave); end
        total++; if (lut_addr !== 9'd0) begin bad++; $display("FAIL midreset lut_addr: got %0d want 0", lut_addr); end
        repeat (12) @(negedge clk);
        total++; if (done_cnt !== c0) begin bad++; $display("FAIL midreset note_done: got %0d pulses want 0", done_cnt - c0); end
    endtask

    initial begin
        reset = 1'b1; fft_done = 1'b0; fft_read_valid = 1'b0; fft_address = '0;
        data_in_real = '0; data_in_imag = '0; min_bin = 9'd0; max_bin = 9'd511;
        threshold = 36'd0; scale = 12'hFFF; result_address = '0; mid_busy = 1'b0;
        clear_frame();
        test_reset();
        test_single_peak("single");
        test_snap("snap_up", {3'd4, 4'd9}, 12'b0101_0000_0000, 6, 1'b1, 4'd10, 3'd4);
        test_snap("oct_wrap_up", {3'd4, 4'd11}, 12'h001, 6, 1'b1, 4'd0, 3'd5);
        test_snap("oct_wrap_dn", {3'd4, 4'd0}, 12'h800, 6, 1'b1, 4'd11, 3'd3);
        test_snap("oct_sat", {3'd7, 4'd11}, 12'h001, 6, 1'b1, 4'd0, 3'd7);
        test_snap("far_snap", {3'd4, 4'd0}, 12'h040, 11, 1'b1, 4'd6, 3'd4);
        test_snap("bad_name", {3'd4, 4'd13}, 12'hFFF, 5, 1'b0, 4'd0, 3'd0);
        test_snap("empty_scale", {3'd4, 4'd9}, 12'h000, 5, 1'b0, 4'd0, 3'd0);
        test_threshold_tie();
        test_window();
        test_abort();
        test_reset_mid();
        test_single_peak("back_to_back");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_note_detector.md
Name: fft_note_detector

Overview:
- Parametrised successor to the main note-detection FSM.
- Consumes one FFT frame of 2^ADDR_W complex bins streamed from the FFT core, computes |X|^2 per bin, stores the magnitudes in a readable buffer, and tracks the peak bin within a programmable bin window with a noise threshold.
- Maps the peak bin to a note through an external bin-to-note ROM, then snaps that note to the nearest note permitted by the 12-bit scale mask.
- Feeds the pitch-correction stage.

Parameters:
- DATA_W, 18, signed width of FFT real/imag samples.
- ADDR_W, 9, bin address width; frame length N = 2^ADDR_W.
- MAG_W, 2*DATA_W, magnitude width; must be >= 2*DATA_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fft_done  in  1  frame-active; high while the FFT streams bins.
- fft_read_valid  in  1  current bin valid.
- fft_address  in  ADDR_W  current bin index.
- data_in_real  in  DATA_W  signed real part.
- data_in_imag  in  DATA_W  signed imaginary part.
- min_bin  in  ADDR_W  lowest bin eligible for peak.
- max_bin  in  ADDR_W  highest bin eligible for peak.
- threshold  in  MAG_W  peak must be strictly greater to be valid.
- scale  in  12  bit i set = note i allowed (0=C..11=B).
- lut_addr  out  ADDR_W  bin-to-note ROM address.
- lut_data  in  7  {octave[2:0], name[3:0]}; registered ROM, 1-cycle latency.
- result_address  in  ADDR_W  magnitude buffer read address.
- result_data  out  MAG_W  magnitude at result_address, 1-cycle latency.
- busy  out  1  high when not IDLE.
- note_done  out  1  1-cycle pulse when the frame result is final.
- note_valid  out  1  last result valid.
- note_name  out  4  snapped note.
- note_octave  out  3  snapped octave.
- peak_bin  out  ADDR_W  peak bin index.
- peak_mag  out  MAG_W  peak magnitude.

Behaviour:
- Reset: state=IDLE. All outputs, pipeline, peak registers and lut_addr go to 0. The magnitude RAM is not reset.
- Sample accepted in a cycle only if fft_done && fft_read_valid.
- Magnitude pipeline:
  - Stage 1 registers re*re and im*im, unsigned, MAG_W bits each.
  - Stage 2 registers their sum. No overflow is possible: max 2^(2*DATA_W-1).
  - Stage 2 writes RAM[addr delayed 2] and updates the peak.
- Peak update rules:
  - Only if min_bin <= addr <= max_bin.
  - Only if mag > running peak (strict); ties keep the lower bin.
  - If min_bin > max_bin, no bin qualifies: peak stays 0 and note_valid=0.
- IDLE: go to ACCUM on an accepted sample with fft_address==0. That sample is processed, and the running peak and peak bin are cleared. Accepted samples with nonzero address are ignored.
- ACCUM:
  - An accepted sample with address N-1 moves to DRAIN.
  - fft_done falling before then aborts to IDLE: no note_done, outputs hold previous values.
  - Addresses are not checked for continuity.
- DRAIN: 2 cycles to flush the pipeline, then:
  - If peak_mag <= threshold: go to DONE with note_valid=0.
  - Otherwise go to LOOKUP.
- LOOKUP: lut_addr=peak_bin for 1 cycle, then SNAP.
- SNAP, with raw {o,n}=lut_data latched on entry:
  - If n>11 or scale==0: note_valid=0, go to DONE.
  - Distance d starts at 0 and is tested one per cycle, up to 6.
  - At each d, test n+d first, then n-d.
  - Upward wrap past 11 gives name-12 and octave+1, saturating at 7.
  - Downward wrap below 0 gives name+12 and octave-1, saturating at 0.
  - First allowed note is latched with note_valid=1, then DONE.
- DONE: assert note_done for 1 cycle, update peak_bin, peak_mag, note_* and note_valid, go to IDLE.
- Latency, with t = cycle the last bin is accepted:
  - Valid path: note_done in cycle t+5+d.
  - Below-threshold path: note_done in cycle t+3.
- busy is high from the first ACCUM cycle through DONE inclusive.
- Frames arriving while busy and not in IDLE are ignored until IDLE.
- result_data may be read any time. Reads during ACCUM return a mix of old and new frame contents. Read and write to the same address in the same cycle return the old data.
- Reset mid-frame: IDLE next cycle, no note_done.

Test Plan:
- All frames use N=512, threshold=0 and scale=12'hFFF unless stated.
- Single peak: bin 40 re=1000 im=0, all other bins 0; LUT[40]={4,9} -> peak_bin=40, peak_mag=1000000, note A4 (9/4), note_valid=1, note_done at t+5; result_address=40 returns 1000000 next cycle.
- Snap up: as above with scale=12'b0101_0000_0000, bit 9 clear and bits 8 and 10 set -> note_name=10, octave 4, note_done at t+6.
- Octave wrap: LUT gives {4,11}, scale=12'h001 -> note_name=0, octave=5 at d=1.
- Threshold and tie: bins 30 and 60 both at mag 500, threshold 500 -> note_valid=0, note_done at t+3. Same frame with threshold 499 -> peak_bin=30.
- Window: peak at bin 5, min_bin=10, smaller peak at bin 20 -> peak_bin=20.
- Abort and reset: fft_done drops at address 200 -> no note_done, busy=0. reset pulsed mid-ACCUM -> all outputs 0. Next full frame still gives the correct result.
